// File: rtl/sd_init_sequencer_if.sv
// rtl/sd_init_sequencer_if.sv - command-master port bundle driven by the SD init sequencer
interface sd_init_sequencer_if;
  logic        start_o;
  logic [13:0] command_o;
  logic [31:0] argument_o;
  logic [15:0] timeout_o;
  logic        int_status_rst_o;
  logic [4:0]  int_status_i;
  logic [31:0] response_0_i;

  modport master (
    output start_o, command_o, argument_o, timeout_o, int_status_rst_o,
    input  int_status_i, response_0_i
  );

  modport slave (
    input  start_o, command_o, argument_o, timeout_o, int_status_rst_o,
    output int_status_i, response_0_i
  );
endinterface

// File: rtl/sd_init_sequencer.sv
// rtl/sd_init_sequencer.sv - SD card identification sequencer (CMD0, CMD8, CMD55/ACMD41, CMD2, CMD3)
module sd_init_sequencer #(
  parameter logic [15:0] CMD_TIMEOUT = 16'd4095,
  parameter logic [15:0] POLL_DELAY  = 16'd1000,
  parameter logic [15:0] MAX_RETRIES = 16'd1000
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [2:0]           err_code_o,
  output logic                 v2_o,
  output logic                 ccs_o,
  output logic [15:0]          rca_o,
  sd_init_sequencer_if.master  cmd_if
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DELAY, S_DONE, S_FAIL
  } state_t;

  typedef enum logic [2:0] {
    ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD2, ST_CMD3
  } step_t;

  localparam int STAT_EI  = 1;
  localparam int STAT_CTE = 2;

  state_t      r_state, w_state_next;
  step_t       r_step, w_step_next;
  logic        r_done, w_done_next;
  logic        r_error, w_error_next;
  logic [2:0]  r_err_code, w_err_code_next;
  logic        r_v2, w_v2_next;
  logic        r_ccs, w_ccs_next;
  logic [15:0] r_rca, w_rca_next;
  logic [15:0] r_retry, w_retry_next;
  logic [15:0] r_delay, w_delay_next;
  logic [4:0]  r_status, w_status_next;
  logic [13:0] r_command, w_command_next;
  logic [31:0] r_argument, w_argument_next;
  logic        w_delay_last;
  logic        w_unused;

  function automatic logic [13:0] cmd_word(input step_t step);
    case (step)
      ST_CMD0:   cmd_word = 14'h0000;
      ST_CMD8:   cmd_word = 14'h0819;
      ST_CMD55:  cmd_word = 14'h3719;
      ST_ACMD41: cmd_word = 14'h2901;
      ST_CMD2:   cmd_word = 14'h020A;
      ST_CMD3:   cmd_word = 14'h0319;
      default:   cmd_word = 14'h0000;
    endcase
  endfunction

  function automatic logic [31:0] cmd_arg(input step_t step, input logic v2);
    case (step)
      ST_CMD8:   cmd_arg = 32'h0000_01AA;
      ST_ACMD41: cmd_arg = {1'b0, v2, 6'b0, 24'hFF8000};
      default:   cmd_arg = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [2:0] step_code(input step_t step);
    case (step)
      ST_CMD0:   step_code = 3'd1;
      ST_CMD8:   step_code = 3'd2;
      ST_CMD55:  step_code = 3'd3;
      ST_ACMD41: step_code = 3'd3;
      ST_CMD2:   step_code = 3'd5;
      ST_CMD3:   step_code = 3'd6;
      default:   step_code = 3'd0;
    endcase
  endfunction

  // 17-bit compare so a zero POLL_DELAY still leaves DELAY after one cycle
  assign w_delay_last = ({1'b0, r_delay} + 17'd1) >= {1'b0, POLL_DELAY};

  always_comb begin
    w_state_next    = r_state;
    w_step_next     = r_step;
    w_done_next     = r_done;
    w_error_next    = r_error;
    w_err_code_next = r_err_code;
    w_v2_next       = r_v2;
    w_ccs_next      = r_ccs;
    w_rca_next      = r_rca;
    w_retry_next    = r_retry;
    w_delay_next    = r_delay;
    w_status_next   = r_status;
    w_command_next  = r_command;
    w_argument_next = r_argument;

    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          w_done_next     = 1'b0;
          w_error_next    = 1'b0;
          w_err_code_next = 3'd0;
          w_v2_next       = 1'b0;
          w_ccs_next      = 1'b0;
          w_rca_next      = 16'd0;
          w_retry_next    = 16'd0;
          w_step_next     = ST_CMD0;
          w_state_next    = S_ISSUE;
        end
      end

      S_ISSUE: w_state_next = S_WAIT;

      S_WAIT: begin
        if (cmd_if.int_status_i != 5'd0) begin
          w_status_next = cmd_if.int_status_i;
          w_state_next  = S_CHECK;
        end
      end

      S_CHECK: begin
        if (r_status[STAT_EI]) begin
          // A v1 card does not answer CMD8, which shows up as a timeout
          if (r_step == ST_CMD8 && r_status[STAT_CTE]) begin
            w_v2_next    = 1'b0;
            w_step_next  = ST_CMD55;
            w_state_next = S_ISSUE;
          end else begin
            w_err_code_next = step_code(r_step);
            w_error_next    = 1'b1;
            w_state_next    = S_FAIL;
          end
        end else begin
          case (r_step)
            ST_CMD0: begin
              w_step_next  = ST_CMD8;
              w_state_next = S_ISSUE;
            end
            ST_CMD8: begin
              if (cmd_if.response_0_i[11:0] != 12'h1AA) begin
                w_err_code_next = 3'd2;
                w_error_next    = 1'b1;
                w_state_next    = S_FAIL;
              end else begin
                w_v2_next    = 1'b1;
                w_step_next  = ST_CMD55;
                w_state_next = S_ISSUE;
              end
            end
            ST_CMD55: begin
              if (r_retry < MAX_RETRIES) begin
                w_retry_next = r_retry + 16'd1;
              end
              w_step_next  = ST_ACMD41;
              w_state_next = S_ISSUE;
            end
            ST_ACMD41: begin
              if (cmd_if.response_0_i[31]) begin
                w_ccs_next   = cmd_if.response_0_i[30];
                w_step_next  = ST_CMD2;
                w_state_next = S_ISSUE;
              end else if (r_retry >= MAX_RETRIES) begin
                w_err_code_next = 3'd4;
                w_error_next    = 1'b1;
                w_state_next    = S_FAIL;
              end else begin
                w_delay_next = 16'd0;
                w_state_next = S_DELAY;
              end
            end
            ST_CMD2: begin
              w_step_next  = ST_CMD3;
              w_state_next = S_ISSUE;
            end
            ST_CMD3: begin
              w_rca_next   = cmd_if.response_0_i[31:16];
              w_done_next  = 1'b1;
              w_state_next = S_DONE;
            end
            default: begin
              w_err_code_next = 3'd0;
              w_error_next    = 1'b1;
              w_state_next    = S_FAIL;
            end
          endcase
        end
      end

      S_DELAY: begin
        if (w_delay_last) begin
          w_step_next  = ST_CMD55;
          w_state_next = S_ISSUE;
        end else begin
          w_delay_next = r_delay + 16'd1;
        end
      end

      default: w_state_next = S_IDLE;
    endcase

    // Command word is latched on the way into ISSUE, so it is frozen through WAIT
    if (w_state_next == S_ISSUE) begin
      w_command_next  = cmd_word(w_step_next);
      w_argument_next = cmd_arg(w_step_next, w_v2_next);
    end
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_step     <= ST_CMD0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= 3'd0;
      r_v2       <= 1'b0;
      r_ccs      <= 1'b0;
      r_rca      <= 16'd0;
      r_retry    <= 16'd0;
      r_delay    <= 16'd0;
      r_status   <= 5'd0;
      r_command  <= 14'd0;
      r_argument <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_step     <= w_step_next;
      r_done     <= w_done_next;
      r_error    <= w_error_next;
      r_err_code <= w_err_code_next;
      r_v2       <= w_v2_next;
      r_ccs      <= w_ccs_next;
      r_rca      <= w_rca_next;
      r_retry    <= w_retry_next;
      r_delay    <= w_delay_next;
      r_status   <= w_status_next;
      r_command  <= w_command_next;
      r_argument <= w_argument_next;
    end
  end

  assign busy_o     = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                      (r_state == S_CHECK) || (r_state == S_DELAY);
  assign done_o     = r_done;
  assign error_o    = r_error;
  assign err_code_o = r_err_code;
  assign v2_o       = r_v2;
  assign ccs_o      = r_ccs;
  assign rca_o      = r_rca;

  assign cmd_if.start_o          = (r_state == S_ISSUE);
  assign cmd_if.int_status_rst_o = (r_state == S_ISSUE) || (r_state == S_CHECK);
  assign cmd_if.command_o        = r_command;
  assign cmd_if.argument_o       = r_argument;
  assign cmd_if.timeout_o        = CMD_TIMEOUT;

  assign w_unused = ^{cmd_if.response_0_i[15:12], r_status[4:3], r_status[0]};

endmodule

// File: doc/sd_init_sequencer.md
# sd_init_sequencer

Autonomous SD card identification sequencer that drives the `sd_cmd_master` command port. On request it issues CMD0, CMD8, then CMD55/ACMD41 until the card is ready, then CMD2 and CMD3. It reports card version, capacity class and RCA. While `busy_o` is high it owns the command master; an external mux selects between this block and the host register file using `busy_o`.

## Interface
- `CMD_TIMEOUT`, 16'd4095: value driven on `timeout_o`, in sd_clk cycles.
- `POLL_DELAY`, 16'd1000: idle cycles between an unready ACMD41 response and the next CMD55.
- `MAX_RETRIES`, 16'd1000: maximum number of ACMD41 issues.

Ports (clock and reset first):
- `sd_clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `start_i` in 1: begin identification. Level, sampled in IDLE/DONE/FAIL.
- `busy_o` out 1: sequence in progress; command-port mux select.
- `done_o` out 1: sequence succeeded. Held until the next start or reset.
- `error_o` out 1: sequence failed. Held until the next start or reset.
- `err_code_o` out 3: failing step. 1=CMD0, 2=CMD8, 3=CMD55/ACMD41, 4=retries exhausted, 5=CMD2, 6=CMD3.
- `v2_o` out 1: card answered CMD8 correctly.
- `ccs_o` out 1: OCR[30] from the final ACMD41.
- `rca_o` out 16: RCA from CMD3 response.
- `start_o` out 1: command master start pulse.
- `command_o` out 14: command master command word. [13:8]=index, [4]=index check, [3]=crc check, [2]=busy check, [1:0]=response type.
- `argument_o` out 32: command argument.
- `timeout_o` out 16: constant `CMD_TIMEOUT`.
- `int_status_rst_o` out 1: clear pulse for the command master status.
- `int_status_i` in 5: {CIE, CCRCE, CTE, EI, CC}. Nonzero only when the master is idle.
- `response_0_i` in 32: card response bits [39:8] (R1/R3/R6/R7 payload).

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, DELAY, DONE, FAIL. A step register selects CMD0, CMD8, CMD55, ACMD41, CMD2 or CMD3.
- Command words and arguments per step:
  - CMD0: 14'h0000, arg 0.
  - CMD8: 14'h0819, arg 32'h000001AA.
  - CMD55: 14'h3719, arg 0.
  - ACMD41: 14'h2901, arg `{1'b0, v2_o, 6'b0, 24'hFF8000}`.
  - CMD2: 14'h020A, arg 0.
  - CMD3: 14'h0319, arg 0.
- IDLE/DONE/FAIL, on `start_i`:
  - Clear `done_o`, `error_o`, `err_code_o`, `v2_o`, `ccs_o`, `rca_o` and the retry counter.
  - Set step to CMD0 and go to ISSUE.
- ISSUE: `start_o`=1 and `int_status_rst_o`=1 for exactly this cycle. `command_o`/`argument_o` were loaded on entry and stay stable until the next ISSUE. Next state is WAIT.
- WAIT: hold until `int_status_i` != 0, then capture it and go to CHECK.
- CHECK: `int_status_rst_o`=1 for this cycle, then decide:
  - EI set, step CMD8, CTE set: `v2_o`=0, go to CMD55 (v1 card).
  - EI set, any other case: go to FAIL with the step's code.
  - CMD0 OK: go to CMD8.
  - CMD8 OK: if `response_0_i[11:0]` != 12'h1AA, go to FAIL code 2. Otherwise `v2_o`=1, go to CMD55.
  - CMD55 OK: go to ACMD41 and increment the retry counter.
  - ACMD41 OK with `response_0_i[31]`=1: `ccs_o`=`response_0_i[30]`, go to CMD2.
  - ACMD41 OK with bit31=0: if retry count == `MAX_RETRIES`, go to FAIL code 4. Otherwise go to DELAY.
  - CMD2 OK: go to CMD3.
  - CMD3 OK: `rca_o`=`response_0_i[31:16]`, go to DONE.
- DELAY: count `POLL_DELAY` cycles, then ISSUE CMD55.
- DONE: `done_o`=1. FAIL: `error_o`=1. In both, `busy_o`=0.
- `busy_o`=1 in ISSUE, WAIT, CHECK and DELAY.
- `start_i` while busy is ignored.

## Timing
- Reset values: all outputs 0 except `timeout_o`=`CMD_TIMEOUT`. State is IDLE.
- Reset mid-operation returns to reset values immediately and issues no further `start_o`.
- `start_i` high at edge N puts the block in ISSUE in cycle N+1 (`start_o` high) and WAIT in N+2. `busy_o` rises at N+1.
- Status sampled in WAIT at edge M gives CHECK in M+1. The next ISSUE follows in M+2, or DELAY starts in M+2.
- CMD55-to-CMD55 gap after an unready ACMD41: CHECK + `POLL_DELAY` + 1 cycles.
- The retry counter is 16 bits and saturates at `MAX_RETRIES`; it never wraps.
- `start_o` is never high in two consecutive cycles.
- The command word is never changed while the master executes (WAIT).

## Test plan
- **v2 SDHC card:** CMD8 returns 0x000001AA; ACMD41 returns 0x00FF8000 twice, then 0xC0FF8000; CMD3 returns 0x12340500. Required: command index order 0,8,55,41,55,41,55,41,2,3; ACMD41 arg 0x40FF8000; `done_o`=1, `v2_o`=1, `ccs_o`=1, `rca_o`=0x1234.
- **v1 card:** CMD8 status 0x06 (CTE+EI). Required: continues with CMD55; ACMD41 arg 0x00FF8000; `v2_o`=0; `done_o`=1.
- **CMD8 echo mismatch:** CMD8 returns 0x000001A5. Required: `error_o`=1, `err_code_o`=2, no further `start_o`, `busy_o`=0.
- **Retries exhausted:** `MAX_RETRIES`=3, `POLL_DELAY`=10, ACMD41 always 0x00FF8000. Required: exactly 3 ACMD41 issued; each gap matches the formula; `err_code_o`=4.
- **CMD2 CRC error:** CMD2 status 0x0B. Required: `err_code_o`=5; `int_status_rst_o` pulses once in CHECK.
- **Reset mid-WAIT:** assert `rst` during CMD55 WAIT. Required: all outputs return to reset values immediately; a later `start_i` restarts from CMD0.
